// File: rtl/xbar_chain_control.sv
// Crossbar configuration controller: shifts a NUM_WORDS x WORD_W image MSB-first into the
// crossbar serial chain on a divided clock, latches it with pclk and captures the returned bits.
module xbar_chain_control #(
    parameter int POSITION  = 0,
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 16,
    parameter int CLK_DIV   = 4
) (
    input  logic        ebi_clk,
    input  logic        reset_n,
    input  logic        cmd_bus_enable,
    input  logic        cmd_bus_wr,
    input  logic        re,
    input  logic [15:0] cmd_bus_addr,
    input  logic [31:0] cmd_bus_data,
    output logic [15:0] data_out,
    output logic        xbar_clock,
    output logic        pclk,
    output logic        sin,
    input  logic        sout
);

    localparam int N  = NUM_WORDS * WORD_W;
    localparam int KW = $clog2(N);
    localparam logic [KW-1:0] K_LAST  = KW'(N - 1);
    localparam logic [7:0]    PH_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0]    POS8    = 8'(POSITION);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    // Images are flat vectors: word 0 sits in the top WORD_W bits, so bit k of the
    // stream is always vector bit N-1-k.
    logic [N-1:0]    r_cfg;
    logic [N-1:0]    r_rb;
    state_t          r_state;
    logic [7:0]      r_phase;
    logic [KW-1:0]   r_k;
    logic            r_xbar_clock;
    logic            r_pclk;
    logic            r_sin;
    logic            r_done;
    logic            r_aborted;
    logic [15:0]     r_data_out;

    logic            w_cs;
    logic [7:0]      w_off;
    logic            w_busy;
    logic            w_cmd_wr;
    logic            w_start;
    logic            w_abort;
    logic            w_cfg_wr;
    logic [KW-1:0]   w_pos;
    logic [KW-1:0]   w_k_next;
    logic [KW-1:0]   w_pos_next;
    logic [WORD_W-1:0] w_rb_word;
    logic [31:0]     w_rb_word32;
    logic [15:0]     w_rd_data;

    assign w_cs       = cmd_bus_enable & (cmd_bus_addr[15:8] == POS8);
    assign w_off      = cmd_bus_addr[7:0];
    assign w_busy     = (r_state != ST_IDLE);
    assign w_cmd_wr   = w_cs & cmd_bus_wr & (w_off == 8'h80);
    assign w_abort    = w_cmd_wr & cmd_bus_data[1];
    assign w_start    = w_cmd_wr & cmd_bus_data[0] & ~cmd_bus_data[1];
    assign w_cfg_wr   = w_cs & cmd_bus_wr & (w_off[7:5] == 3'b000) & ~w_busy;
    assign w_pos      = K_LAST - r_k;
    assign w_k_next   = r_k + KW'(1);
    assign w_pos_next = K_LAST - w_k_next;

    assign data_out   = r_data_out;
    assign xbar_clock = r_xbar_clock;
    assign pclk       = r_pclk;
    assign sin        = r_sin;

    // Read mux: readback halves, ID and status.
    always_comb begin
        w_rb_word = '0;
        w_rd_data = 16'h0000;
        for (int w = 0; w < NUM_WORDS; w++) begin
            w_rb_word = (w_off[5:1] == 5'(w)) ? r_rb[(NUM_WORDS-1-w)*WORD_W +: WORD_W] : w_rb_word;
        end
        w_rb_word32 = 32'(w_rb_word);
        if (w_off[7:6] == 2'b01) begin
            w_rd_data = w_off[0] ? w_rb_word32[31:16] : w_rb_word32[15:0];
        end else if (w_off == 8'h81) begin
            w_rd_data = 16'h7ba3;
        end else if (w_off == 8'h82) begin
            w_rd_data = {13'b0, r_aborted, r_done, w_busy};
        end else begin
            w_rd_data = 16'h0000;
        end
    end

    // Registered read data, cleared in every cycle without a read.
    always_ff @(posedge ebi_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= 16'h0000;
        end else begin
            r_data_out <= (w_cs & re) ? w_rd_data : 16'h0000;
        end
    end

    // Configuration image; writes are dropped while a transfer is running.
    always_ff @(posedge ebi_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cfg <= '0;
        end else if (w_cfg_wr) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                if (w_off[4:0] == 5'(w)) begin
                    r_cfg[(NUM_WORDS-1-w)*WORD_W +: WORD_W] <= cmd_bus_data[WORD_W-1:0];
                end
            end
        end
    end

    // Transfer FSM with registered chain outputs and readback capture.
    always_ff @(posedge ebi_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_phase      <= 8'd0;
            r_k          <= '0;
            r_xbar_clock <= 1'b0;
            r_pclk       <= 1'b1;
            r_sin        <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_rb         <= '0;
        end else if (r_state == ST_IDLE) begin
            r_xbar_clock <= 1'b0;
            r_pclk       <= 1'b1;
            r_phase      <= 8'd0;
            if (w_start) begin
                r_state   <= ST_SETUP;
                r_k       <= '0;
                r_sin     <= r_cfg[K_LAST];
                r_done    <= 1'b0;
                r_aborted <= 1'b0;
            end else begin
                r_sin     <= 1'b0;
            end
        end else if (w_abort) begin
            r_state      <= ST_IDLE;
            r_phase      <= 8'd0;
            r_xbar_clock <= 1'b0;
            r_sin        <= 1'b0;
            r_pclk       <= 1'b1;
            r_aborted    <= 1'b1;
        end else begin
            case (r_state)
                ST_SETUP: begin
                    if (r_phase == PH_LAST) begin
                        // sout is taken on the edge that raises xbar_clock, i.e. before the chain shifts.
                        r_phase      <= 8'd0;
                        r_state      <= ST_HIGH;
                        r_xbar_clock <= 1'b1;
                        r_rb[w_pos]  <= sout;
                    end else begin
                        r_phase <= r_phase + 8'd1;
                    end
                end
                ST_HIGH: begin
                    if (r_phase == PH_LAST) begin
                        r_phase      <= 8'd0;
                        r_xbar_clock <= 1'b0;
                        if (r_k == K_LAST) begin
                            r_state <= ST_LATCH;
                            r_pclk  <= 1'b0;
                            r_sin   <= 1'b0;
                        end else begin
                            r_state <= ST_SETUP;
                            r_k     <= w_k_next;
                            r_sin   <= r_cfg[w_pos_next];
                        end
                    end else begin
                        r_phase <= r_phase + 8'd1;
                    end
                end
                ST_LATCH: begin
                    if (r_phase == PH_LAST) begin
                        r_phase <= 8'd0;
                        r_state <= ST_IDLE;
                        r_pclk  <= 1'b1;
                        r_done  <= 1'b1;
                    end else begin
                        r_phase <= r_phase + 8'd1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_phase      <= 8'd0;
                    r_xbar_clock <= 1'b0;
                    r_pclk       <= 1'b1;
                    r_sin        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xbar_chain_control.sv
// Directed bench for xbar_chain_control: chain model, sin scoreboard, bus and reset checks.
module tb_xbar_chain_control;

    logic        ebi_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic        wr = 1'b0;
    logic        re = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [31:0] wdata = 32'h0;
    logic [15:0] data_out;
    logic        xbar_clock;
    logic        pclk;
    logic        sin;
    logic        sout;

    logic [15:0] chain;
    logic [15:0] chain_init = 16'h0000;
    logic        chain_load = 1'b0;

    bit exp_q[$];
    bit obs_q[$];
    int n_edges      = 0;
    int pclk_low_cnt = 0;
    int pclk_fall_at = 0;
    int n_cmp = 0;
    int n_err = 0;

    xbar_chain_control #(
        .POSITION (3),
        .WORD_W   (8),
        .NUM_WORDS(2),
        .CLK_DIV  (2)
    ) dut (
        .ebi_clk       (ebi_clk),
        .reset_n       (reset_n),
        .cmd_bus_enable(en),
        .cmd_bus_wr    (wr),
        .re            (re),
        .cmd_bus_addr  (addr),
        .cmd_bus_data  (wdata),
        .data_out      (data_out),
        .xbar_clock    (xbar_clock),
        .pclk          (pclk),
        .sin           (sin),
        .sout          (sout)
    );

    always #5 ebi_clk = ~ebi_clk;

    // Crossbar chain: 16-bit shift register, output is its MSB.
    always @(posedge xbar_clock or posedge chain_load) begin
        if (chain_load) chain <= chain_init;
        else            chain <= {chain[14:0], sin};
    end
    assign sout = chain[15];

    always @(posedge xbar_clock) begin
        obs_q.push_back(sin);
        n_edges <= n_edges + 1;
    end

    always @(negedge ebi_clk) begin
        if (pclk === 1'b0) pclk_low_cnt <= pclk_low_cnt + 1;
    end

    always @(negedge pclk) pclk_fall_at <= n_edges;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Caller sits at a negedge; returns at the negedge after the write edge.
    task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
        en = 1'b1; wr = 1'b1; addr = a; wdata = d;
        @(negedge ebi_clk);
        en = 1'b0; wr = 1'b0; wdata = 32'h0;
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [15:0] d);
        en = 1'b1; re = 1'b1; addr = a;
        @(negedge ebi_clk);
        en = 1'b0; re = 1'b0;
        d = data_out;
    endtask

    task automatic push_bits(input logic [15:0] img, input int nbits);
        for (int i = 0; i < nbits; i++) exp_q.push_back(img[15-i]);
    endtask

    task automatic check_bits(input string tag);
        bit e;
        bit o;
        int idx;
        idx = 0;
        chk({tag, "_edges"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk($sformatf("%s_sin%0d", tag, idx), 32'(o), 32'(e));
            idx++;
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic poll_done(output int busy_cnt, output logic [15:0] st);
        busy_cnt = 0;
        st = 16'hffff;
        for (int i = 0; i < 300; i++) begin
            bus_rd(16'h0382, st);
            if (st[0]) busy_cnt++;
            else break;
        end
    endtask

    task automatic load_chain(input logic [15:0] v);
        chain_init = v;
        chain_load = 1'b1;
        #1;
        chain_load = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge ebi_clk);
    endtask

    initial begin
        logic [15:0] rd;
        int busy_cnt;
        int e0;
        int p0;

        repeat (3) @(negedge ebi_clk);
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_xbar_clock", 32'(xbar_clock), 32'h0);
        chk("rst_pclk", 32'(pclk), 32'h1);
        chk("rst_sin", 32'(sin), 32'h0);
        reset_n = 1'b1;
        load_chain(16'hbeef);
        @(negedge ebi_clk);

        bus_rd(16'h0382, rd);
        chk("rst_status", 32'(rd), 32'h0000);
        bus_rd(16'h0381, rd);
        chk("id_read", 32'(rd), 32'h7ba3);
        idle(1);
        chk("data_out_idle", 32'(data_out), 32'h0);
        bus_rd(16'h0481, rd);
        chk("other_position", 32'(rd), 32'h0);

        // Configuration shift and readback.
        bus_wr(16'h0300, 32'h0000_00a5);
        bus_wr(16'h0301, 32'hffff_ff3c);
        e0 = n_edges;
        p0 = pclk_low_cnt;
        bus_wr(16'h0380, 32'h1);
        push_bits(16'ha53c, 16);
        poll_done(busy_cnt, rd);
        chk("shift_busy_cycles", 32'(busy_cnt), 32'd66);
        chk("shift_status", 32'(rd), 32'h0002);
        check_bits("shift");
        chk("shift_pclk_low", 32'(pclk_low_cnt - p0), 32'd2);
        chk("shift_pclk_after_edge", 32'(pclk_fall_at - e0), 32'd16);
        chk("shift_chain", 32'(chain), 32'ha53c);
        bus_rd(16'h0340, rd);
        chk("rb0_lo", 32'(rd), 32'h00be);
        bus_rd(16'h0342, rd);
        chk("rb1_lo", 32'(rd), 32'h00ef);
        bus_rd(16'h0341, rd);
        chk("rb0_hi", 32'(rd), 32'h0000);
        bus_rd(16'h0343, rd);
        chk("rb1_hi", 32'(rd), 32'h0000);

        // CFG write and START while busy are both ignored.
        bus_wr(16'h0380, 32'h1);
        push_bits(16'ha53c, 16);
        bus_wr(16'h0300, 32'h0000_00ff);
        bus_wr(16'h0380, 32'h1);
        poll_done(busy_cnt, rd);
        chk("busy_rules_cycles", 32'(busy_cnt), 32'd64);
        chk("busy_rules_status", 32'(rd), 32'h0002);
        check_bits("busy_rules");

        // Abort after the 5th rising edge.
        e0 = n_edges;
        p0 = pclk_low_cnt;
        bus_wr(16'h0380, 32'h1);
        push_bits(16'ha53c, 5);
        for (int c = 0; c < 100 && (n_edges - e0) < 5; c++) @(negedge ebi_clk);
        chk("abort_wait", 32'(n_edges - e0), 32'd5);
        chk("abort_pre_xbar", 32'(xbar_clock), 32'h1);
        bus_wr(16'h0380, 32'h2);
        chk("abort_xbar", 32'(xbar_clock), 32'h0);
        chk("abort_sin", 32'(sin), 32'h0);
        idle(20);
        chk("abort_pclk_low", 32'(pclk_low_cnt - p0), 32'd0);
        bus_rd(16'h0382, rd);
        chk("abort_status", 32'(rd), 32'h0004);
        check_bits("abort");

        // Asynchronous reset at the 7th rising edge.
        e0 = n_edges;
        p0 = pclk_low_cnt;
        bus_wr(16'h0380, 32'h1);
        push_bits(16'ha53c, 7);
        for (int c = 0; c < 100 && (n_edges - e0) < 7; c++) @(negedge ebi_clk);
        chk("reset_wait", 32'(n_edges - e0), 32'd7);
        chk("reset_pre_xbar", 32'(xbar_clock), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("reset_xbar", 32'(xbar_clock), 32'h0);
        chk("reset_pclk", 32'(pclk), 32'h1);
        chk("reset_sin", 32'(sin), 32'h0);
        idle(2);
        reset_n = 1'b1;
        idle(20);
        chk("reset_pclk_low", 32'(pclk_low_cnt - p0), 32'd0);
        bus_rd(16'h0382, rd);
        chk("reset_status", 32'(rd), 32'h0000);
        check_bits("reset");

        // Fresh transfer after reset.
        load_chain(16'h1234);
        bus_wr(16'h0300, 32'h5a);
        bus_wr(16'h0301, 32'hc3);
        bus_wr(16'h0380, 32'h1);
        push_bits(16'h5ac3, 16);
        poll_done(busy_cnt, rd);
        chk("fresh_busy_cycles", 32'(busy_cnt), 32'd66);
        chk("fresh_status", 32'(rd), 32'h0002);
        check_bits("fresh");
        chk("fresh_chain", 32'(chain), 32'h5ac3);
        bus_rd(16'h0340, rd);
        chk("fresh_rb0", 32'(rd), 32'h0012);
        bus_rd(16'h0342, rd);
        chk("fresh_rb1", 32'(rd), 32'h0034);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/xbar_chain_control.md
# xbar_chain_control

Parametrised crossbar configuration controller on the EBI command bus. Holds a configuration image of NUM_WORDS × WORD_W bits, shifts it MSB-first into the crossbar serial chain on a self-generated divided clock, latches it with an active-low pclk pulse, and captures the bits returned on the chain output into a readback image for verification. It replaces the fixed 512-bit, externally clocked controller. Derives all timing from ebi_clk.

## Interface
- POSITION, 0: command-bus select; block responds when cmd_bus_addr[15:8] == POSITION.
- WORD_W, 32: configuration word width; legal values 8, 16, 32.
- NUM_WORDS, 16: number of configuration words; range 1..32.
- CLK_DIV, 4: ebi_clk cycles per xbar_clock phase (low and high each); range 1..255.
- ebi_clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_bus_enable  in  1  bus cycle valid.
- cmd_bus_wr  in  1  write strobe.
- re  in  1  read strobe.
- cmd_bus_addr  in  16  [15:8] block select, [7:0] register offset.
- cmd_bus_data  in  32  write data.
- data_out  out  16  registered read data; 0 when not read.
- xbar_clock  out  1  crossbar shift clock.
- pclk  out  1  active-low latch pulse.
- sin  out  1  serial data to chain.
- sout  in  1  serial data returned from chain end.

## Operation
- cs = cmd_bus_enable & (cmd_bus_addr[15:8] == POSITION). Register map, offset [7:0]:
  - 0x00–0x1F: CFG[offset[4:0]], write-only; bits above WORD_W ignored. Offsets ≥ NUM_WORDS ignored.
  - 0x40–0x7F: RB, read-only; word offset[5:1], offset[0]=0 low 16 bits, 1 high 16 bits (0 if WORD_W ≤ 16).
  - 0x80: CMD, write: bit0 START, bit1 ABORT (ABORT wins if both set).
  - 0x81: ID, reads 16'h7ba3.
  - 0x82: STATUS, reads {13'b0, aborted, done, busy}.
- CFG writes while busy are dropped; image is stable during a transfer.
- START while busy is ignored. START in IDLE clears done and aborted.
- Bit order: word 0 first, each word MSB first; total N = NUM_WORDS × WORD_W bits.
- FSM:
  - IDLE: xbar_clock=0, pclk=1, busy=0. On START -> SETUP with bit index k=0.
  - SETUP: sin = bit k, xbar_clock=0, CLK_DIV cycles -> HIGH.
  - HIGH: xbar_clock=1, CLK_DIV cycles. On entry cycle, sout is sampled into RB bit k (word k/WORD_W, bit WORD_W-1-k%WORD_W). Exit: k==N-1 -> LATCH; else k++ -> SETUP.
  - LATCH: pclk=0, sin=0, CLK_DIV cycles -> IDLE; set done.
- ABORT in any non-IDLE state: next cycle IDLE, xbar_clock=0, sin=0, pclk never pulsed, aborted=1, RB keeps partial content.
- RB holds the chain's prior contents after a full transfer (chain length N).
- Reset: all CFG and RB words 0, state IDLE, done=aborted=0.

## Timing
- Reset values: data_out=0, xbar_clock=0, pclk=1, sin=0, busy=0.
- Outputs xbar_clock, pclk, sin are registered (glitch-free).
- Read: data_out valid the cycle after cs & re; 0 in every cycle following one without cs & re.
- START written at cycle t: busy=1 and SETUP from t+1. First xbar_clock rise at t+1+CLK_DIV.
- sin is stable for the full SETUP and HIGH phases of its bit, so it is stable CLK_DIV cycles before and after each rising edge.
- Transfer length: 2·CLK_DIV·N + CLK_DIV cycles from t+1. busy drops and done rises in the same cycle as the return to IDLE.
- Async reset mid-transfer: outputs reach their reset values immediately. There is no pclk pulse, and no restart after release.
- Counters: phase counter 8 bits, bit index ⌈log2(N)⌉ bits. No wrap is possible; k terminates at N-1.

## Test plan
- Parameters for the bench: WORD_W=8, NUM_WORDS=2, CLK_DIV=2, POSITION=3.
- Config shift: write CFG0=0xA5 and CFG1=0x3C, then START. sin at the 16 rising edges must be 1010010100111100. pclk must go low for exactly 2 cycles after the 16th edge. busy must stay high for 66 cycles, then done=1.
- Readback: model the chain as a 16-bit shift register preloaded with 0xBEEF. After the transfer, RB reads at 0x40 = 0x00BE and 0x42 = 0x00EF. The model then holds 0xA53C.
- Abort: START, then write ABORT after the 5th rising edge. Next cycle xbar_clock=0 and sin=0. pclk must stay 1 throughout. STATUS must read 0x0004.
- Bus rules:
  - A CFG write while busy does not change the shifted bits.
  - START while busy has no effect.
  - Reads with POSITION≠3 leave data_out=0.
  - ID reads 0x7ba3 one cycle after re.
- Reset mid-transfer: assert reset_n=0 at edge 7. Outputs go to 0/1/0 (xbar_clock/pclk/sin) asynchronously. STATUS reads 0x0000 after release. A fresh START completes normally.
